axis_sync_fifo: RTL and testbench
=================================

// Module: axis_sync_fifo
// PURPOSE
// - Synchronous AXI-Stream FIFO placed directly upstream of axis_adapter.
// - Absorbs input bursts and decouples producer stalls from adapter backpressure.
// - Carries tdata, tkeep, tlast and tuser unmodified, in order, with no frame awareness.
// PARAMETERS
// - ADDR_WIDTH  4               RAM depth = 2**ADDR_WIDTH words (16)
// - DATA_WIDTH  64              tdata width in bits
// - KEEP_WIDTH  DATA_WIDTH/8    tkeep width in bits
// PORTS
// - clk                 in   1           clock, all logic on rising edge
// - rst                 in   1           reset, synchronous, active-high
// - input_axis_tdata    in   DATA_WIDTH  write data
// - input_axis_tkeep    in   KEEP_WIDTH  byte enables
// - input_axis_tvalid   in   1           write request
// - input_axis_tready   out  1           FIFO can accept a word
// - input_axis_tlast    in   1           end of frame
// - input_axis_tuser    in   1           user/error flag
// - output_axis_tdata   out  DATA_WIDTH  read data, registered
// - output_axis_tkeep   out  KEEP_WIDTH  registered
// - output_axis_tvalid  out  1           registered
// - output_axis_tready  in   1           consumer (axis_adapter) ready
// - output_axis_tlast   out  1           registered
// - output_axis_tuser   out  1           registered
// - status_count        out  ADDR_WIDTH+1  words held in RAM (macro only)
// - status_full         out  1           RAM full (macro only)
// - status_empty        out  1           RAM empty (macro only)
// BEHAVIOUR
// - Storage: RAM of 2**ADDR_WIDTH entries, each {tlast, tuser, tkeep, tdata}.
// - Pointers: wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits.
//   - RAM index = ptr[ADDR_WIDTH-1:0].
//   - Pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
// - empty = (wr_ptr == rd_ptr).
// - full  = MSBs differ and lower ADDR_WIDTH bits are equal.
// - input_axis_tready = ~full & ~rst, decoded from registered pointers (no comb path from output_axis_tready).
// - Write: on input_axis_tvalid & input_axis_tready, store word at wr_ptr, then wr_ptr+1.
// - Output register stage (one word) after the RAM:
//   - Loads when ~empty & (~output_axis_tvalid | output_axis_tready).
//   - On load: registers <= RAM[rd_ptr], output_axis_tvalid <= 1, rd_ptr+1.
//   - Else if output_axis_tready: output_axis_tvalid <= 0.
// - Latency: word accepted at edge N on an empty FIFO gives output_axis_tvalid=1 after edge N+1. No write-to-read bypass.
// - Throughput: 1 word/cycle sustained on both sides when neither side stalls.
// - Capacity: 2**ADDR_WIDTH words in RAM + 1 in the output register.
// - Simultaneous write and load in one cycle are both allowed. Full and empty are recomputed from the updated pointers.
// - Output holds data stable while tvalid=1 & tready=0 (AXI-S rule).
// - Reset values:
//   - wr_ptr = rd_ptr = 0.
//   - output_axis_tvalid/tdata/tkeep/tlast/tuser = 0.
//   - input_axis_tready = 0 while rst is high, 1 on the first cycle after.
// - Reset mid-operation discards all stored words. RAM contents need not be cleared.
// CONFIGURATION
// - Macro AXIS_FIFO_STATUS_EN:
//   - Defined: status_count, status_full, status_empty ports exist and are registered, updated every cycle.
//     - status_count = wr_ptr - rd_ptr (ADDR_WIDTH+1 bits), 0..2**ADDR_WIDTH.
//     - All three reset to count=0, full=0, empty=1.
//   - Not defined: the three ports and their logic are absent; datapath behaviour is identical.
// TESTING
// - Reset, then a single word 0x11 tkeep=0xFF tlast=1 -> output_axis_tvalid rises 2 cycles after the input valid edge; data, tkeep and tlast match.
// - output_axis_tready=0, write 17 words 0..16 -> tready drops after the 17th accepted word (16 RAM + 1 output reg); status_count=16, status_full=1.
// - From full, raise output_axis_tready -> words 0..16 drain in order, one per cycle; input_axis_tready returns 1 cycle after the first read.
// - Continuous valid on both sides with random output_axis_tready (50%) over 1000 words -> no loss, no duplication, order preserved, tuser/tlast aligned.
// - Assert rst with 5 words stored -> next cycle output_axis_tvalid=0, status_empty=1; the next write emerges first.
// - Write and read each cycle for 40 cycles -> pointers wrap past 31 without data error; status_count stays constant.

Source files
------------

// File: rtl/axis_sync_fifo_if.sv
// AXI-Stream bundle shared by the FIFO's input and output sides.
// master drives payload and tvalid; slave drives tready.
interface axis_sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_sync_fifo.sv
// Synchronous AXI-Stream FIFO: 2**ADDR_WIDTH-word RAM followed by a one-word output register.
// Optional status ports (count/full/empty) are built when AXIS_FIFO_STATUS_EN is defined.
module axis_sync_fifo #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_sync_fifo_if.slave       input_axis,
  axis_sync_fifo_if.master      output_axis
`ifdef AXIS_FIFO_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   status_count,
  output logic                  status_full,
  output logic                  status_empty
`endif
);

  localparam int unsigned Depth     = 2 ** ADDR_WIDTH;
  localparam int unsigned WordWidth = DATA_WIDTH + KEEP_WIDTH + 2;

  typedef logic [ADDR_WIDTH:0]  ptr_t;
  typedef logic [WordWidth-1:0] word_t;

  word_t                 mem_q [Depth];
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  logic                  empty, full;
  logic                  wr_en, ld_en;
  word_t                 wr_word, rd_word;

  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic                  out_user_q;
  logic                  out_valid_q;

  // Flags come only from registered pointers, so tready never depends on the consumer.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
            (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  end

  assign input_axis.tready = ~full & ~rst;

  always_comb begin
    wr_en    = input_axis.tvalid & ~full & ~rst;
    ld_en    = ~empty & (~out_valid_q | output_axis.tready);
    wr_ptr_d = wr_ptr_q + ptr_t'(wr_en);
    rd_ptr_d = rd_ptr_q + ptr_t'(ld_en);
    wr_word  = {input_axis.tlast, input_axis.tuser, input_axis.tkeep, input_axis.tdata};
    rd_word  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ld_en) begin
      {out_last_q, out_user_q, out_keep_q, out_data_q} <= rd_word;
      out_valid_q <= 1'b1;
    end else if (output_axis.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign output_axis.tdata  = out_data_q;
  assign output_axis.tkeep  = out_keep_q;
  assign output_axis.tlast  = out_last_q;
  assign output_axis.tuser  = out_user_q;
  assign output_axis.tvalid = out_valid_q;

`ifdef AXIS_FIFO_STATUS_EN
  logic [ADDR_WIDTH:0] status_count_q;
  logic                status_full_q;
  logic                status_empty_q;

  // Computed from next-state pointers so status matches the pointers held after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_count_q <= '0;
      status_full_q  <= 1'b0;
      status_empty_q <= 1'b1;
    end else begin
      status_count_q <= wr_ptr_d - rd_ptr_d;
      status_full_q  <= (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                        (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
      status_empty_q <= (wr_ptr_d == rd_ptr_d);
    end
  end

  assign status_count = status_count_q;
  assign status_full  = status_full_q;
  assign status_empty = status_empty_q;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Randomized bench for axis_sync_fifo: queue-based reference model with a decoupled output monitor.
module tb_axis_sync_fifo;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;

  typedef logic [DW+KW+1:0] word_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  word_t exp_q[$];

  axis_sync_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) in_if ();
  axis_sync_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) out_if ();

`ifdef AXIS_FIFO_STATUS_EN
  logic [AW:0] status_count;
  logic        status_full;
  logic        status_empty;
`endif

  axis_sync_fifo #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .input_axis  (in_if),
    .output_axis (out_if)
`ifdef AXIS_FIFO_STATUS_EN
    ,
    .status_count(status_count),
    .status_full (status_full),
    .status_empty(status_empty)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t mk_word(input logic last, input logic user, input logic [KW-1:0] keep,
                                    input logic [DW-1:0] data);
    return {last, user, keep, data};
  endfunction

  function automatic word_t rnd_word();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    return mk_word(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), KW'($urandom), d);
  endfunction

  task automatic drive(input word_t w);
    {in_if.tlast, in_if.tuser, in_if.tkeep, in_if.tdata} = w;
    in_if.tvalid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: every accepted input word is expected at the output, in order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && in_if.tvalid && in_if.tready)
        exp_q.push_back({in_if.tlast, in_if.tuser, in_if.tkeep, in_if.tdata});
    end
  end

  // Output monitor: compare every handshake and check stability while stalled.
  initial begin
    word_t cur, exp, held;
    bit    stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst && out_if.tvalid) begin
        cur = {out_if.tlast, out_if.tuser, out_if.tkeep, out_if.tdata};
        if (stalled) check("out_stable", cur, held);
        if (out_if.tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_word: got %0h, expected no word", cur);
          end else begin
            exp = exp_q.pop_front();
            check("out_word", cur, exp);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = cur;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_if.tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 500), 1);
  endtask

  initial begin
    int    accepted;
    int    cyc;
    bit    acc;
    rst          = 1'b1;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
    out_if.tready = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_in_tready", in_if.tready, 0);
    check("rst_out_tvalid", out_if.tvalid, 0);
    check("rst_out_tdata", out_if.tdata, 0);
    check("rst_out_tkeep", out_if.tkeep, 0);
`ifdef AXIS_FIFO_STATUS_EN
    check("rst_status", {status_count, status_full, status_empty}, {5'd0, 1'b0, 1'b1});
`endif
    step();
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", in_if.tready, 1);

    // Single word latency
    step();
    out_if.tready = 1'b1;
    drive(mk_word(1'b1, 1'b0, 8'hFF, 64'h11));
    step();
    in_if.tvalid = 1'b0;
    @(negedge clk);
    check("latency_n", out_if.tvalid, 0);
    step();
    @(negedge clk);
    check("latency_n1", out_if.tvalid, 1);
    check("single_tdata", out_if.tdata, 64'h11);
    check("single_tkeep", out_if.tkeep, 8'hFF);
    check("single_tlast", out_if.tlast, 1);
    wait_drain();

    // Fill: 16 RAM words + 1 in the output register
    step();
    out_if.tready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      drive(mk_word((i == 16), 1'b0, 8'hFF, 64'(i)));
      @(negedge clk);
      check("fill_tready", in_if.tready, 1);
      step();
    end
    in_if.tvalid = 1'b0;
    @(negedge clk);
    check("full_tready", in_if.tready, 0);
`ifdef AXIS_FIFO_STATUS_EN
    check("full_count", status_count, 16);
    check("full_flag", status_full, 1);
    check("full_empty", status_empty, 0);
`endif

    // Drain in order, one word per cycle
    step();
    out_if.tready = 1'b1;
    @(negedge clk);
    check("drain_valid", out_if.tvalid, 1);
    check("tready_before_read", in_if.tready, 0);
    step();
    @(negedge clk);
    check("tready_after_read", in_if.tready, 1);
    for (int i = 1; i <= 16; i++) begin
      check("drain_valid", out_if.tvalid, 1);
      step();
      @(negedge clk);
    end
    check("drain_done_valid", out_if.tvalid, 0);
    check("drain_done_queue", exp_q.size(), 0);

    // Random backpressure, continuous input valid
    step();
    accepted = 0;
    cyc      = 0;
    drive(rnd_word());
    while (accepted < 1000 && cyc < 20000) begin
      out_if.tready = 1'($urandom_range(1, 0));
      @(negedge clk);
      acc = in_if.tready;
      step();
      cyc++;
      if (acc) begin
        accepted++;
        drive(rnd_word());
      end
    end
    in_if.tvalid  = 1'b0;
    out_if.tready = 1'b1;
    check("random_count", accepted, 1000);
    wait_drain();

    // Reset with 5 words stored
    step();
    out_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(rnd_word());
      step();
    end
    in_if.tvalid = 1'b0;
    step();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("tready_in_rst", in_if.tready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", out_if.tvalid, 0);
    check("rst_flush_tready", in_if.tready, 1);
`ifdef AXIS_FIFO_STATUS_EN
    check("rst_flush_empty", status_empty, 1);
    check("rst_flush_count", status_count, 0);
`endif
    step();
    drive(mk_word(1'b1, 1'b1, 8'h0F, 64'hABC));
    out_if.tready = 1'b1;
    step();
    in_if.tvalid = 1'b0;
    wait_drain();

    // Simultaneous write and read across pointer wrap
    step();
    out_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rnd_word());
      step();
    end
    in_if.tvalid = 1'b0;
    step();
    @(negedge clk);
    check("wrap_prefill_valid", out_if.tvalid, 1);
`ifdef AXIS_FIFO_STATUS_EN
    check("wrap_prefill_count", status_count, 2);
`endif
    step();
    out_if.tready = 1'b1;
    drive(rnd_word());
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("wrap_out_valid", out_if.tvalid, 1);
      check("wrap_in_tready", in_if.tready, 1);
`ifdef AXIS_FIFO_STATUS_EN
      check("wrap_count", status_count, 2);
`endif
      step();
      drive(rnd_word());
    end
    in_if.tvalid = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
